// File: rtl/sonar_pkg.sv
// Shared constants, parser state encoding and small helpers for the sonar
// serial-frame receiver.
package sonar_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

  localparam logic [6:0] ASCII_ZERO      = 7'h30;
  localparam logic [6:0] ASCII_NOVE      = 7'h39;
  localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;
  localparam logic [6:0] ASCII_CERQUILHA = 7'h23;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_ANG  = 4'd1,
    ST_VIRG = 4'd2,
    ST_DIST = 4'd3,
    ST_FIM  = 4'd4
  } parser_state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [6:0] d, input logic p);
    return ^{d, p};
  endfunction

  function automatic logic is_digit(input logic [6:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NOVE);
  endfunction

  function automatic logic [9:0] bcd3_to_bin(input logic [11:0] b);
    return (10'(b[11:8]) * 10'd100) + (10'(b[7:4]) * 10'd10) + 10'(b[3:0]);
  endfunction

endpackage

// File: rtl/rx_serial_7O1.sv
// 7O1 UART receiver: 2-flop synchronizer, mid-bit sampling and a one-cycle
// ready pulse carrying the character and its parity/stop error flags.
module rx_serial_7O1
  import sonar_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic [6:0] o_dado,
  output logic       o_rx_pronto,
  output logic       o_err_par,
  output logic       o_err_stop
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_shift;

  logic [CNT_W-1:0] w_target;
  logic             w_sample;
  logic             w_fall;

  // Bit 0 (start) is sampled half a bit in; all later bits one full bit apart.
  always_comb begin
    if (r_bit == 4'd0) begin
      w_target = CNT_W'(HALF - 1);
    end else begin
      w_target = CNT_W'(CLKS_PER_BIT - 1);
    end
    w_sample = r_busy && (r_cnt == w_target);
    w_fall   = r_prev && !r_sync2;
  end

  // Synchronizer, bit timing and shift register; r_bit 1..8 = data + parity, 9 = stop.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_prev      <= 1'b1;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_bit       <= 4'd0;
      r_shift     <= 8'd0;
      o_dado      <= 7'd0;
      o_rx_pronto <= 1'b0;
      o_err_par   <= 1'b0;
      o_err_stop  <= 1'b0;
    end else begin
      r_sync1     <= i_rx;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      o_rx_pronto <= 1'b0;
      if (!r_busy) begin
        if (w_fall) begin
          r_busy <= 1'b1;
          r_cnt  <= '0;
          r_bit  <= 4'd0;
        end
      end else if (w_sample) begin
        r_cnt <= '0;
        if (r_bit == 4'd0) begin
          if (r_sync2) begin
            r_busy <= 1'b0;
          end else begin
            r_bit <= 4'd1;
          end
        end else if (r_bit == 4'd9) begin
          r_busy      <= 1'b0;
          o_rx_pronto <= 1'b1;
          o_dado      <= r_shift[6:0];
          o_err_par   <= !odd_parity_ok(r_shift[6:0], r_shift[7]);
          o_err_stop  <= !r_sync2;
        end else begin
          r_shift <= {r_sync2, r_shift[7:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sonar_rx_decoder.sv
// Parses "AAA,DDD#" frames from the sonar serial line and publishes the last
// valid angle/distance in BCD with a proximity alert and frame counters.
module sonar_rx_decoder
  import sonar_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CLKS = 50000,
  parameter int LIMIAR_CM    = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        frame_valido,
  output logic        erro_frame,
  output logic        alerta_proximidade,
  output logic [7:0]  num_quadros,
  output logic [3:0]  db_estado
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [6:0]    w_dado;
  logic          w_pronto;
  logic          w_err_par;
  logic          w_err_stop;

  parser_state_t r_estado;
  parser_state_t w_prox_estado;
  logic [1:0]    r_k;
  logic [1:0]    w_prox_k;
  logic [11:0]   r_ang;
  logic [11:0]   r_dist;
  logic [TMO_W-1:0] r_tmo;

  logic          w_bad;
  logic          w_digit;
  logic          w_timeout;
  logic          w_abort;
  logic          w_commit;
  logic          w_st_ang;
  logic          w_st_dist;

  rx_serial_7O1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clock     (clock),
    .i_reset_n   (reset),
    .i_rx        (entrada_serial),
    .o_dado      (w_dado),
    .o_rx_pronto (w_pronto),
    .o_err_par   (w_err_par),
    .o_err_stop  (w_err_stop)
  );

  assign w_bad     = w_err_par || w_err_stop;
  assign w_digit   = is_digit(w_dado);
  assign w_timeout = (r_estado != ST_IDLE) && (r_tmo == TMO_W'(TIMEOUT_CLKS - 1));

  // Next-state logic; a received character always takes precedence over the timeout.
  always_comb begin
    w_prox_estado = r_estado;
    w_prox_k      = r_k;
    w_abort       = 1'b0;
    w_commit      = 1'b0;
    w_st_ang      = 1'b0;
    w_st_dist     = 1'b0;
    if (w_pronto) begin
      case (r_estado)
        ST_IDLE: begin
          if (!w_bad && w_digit) begin
            w_st_ang      = 1'b1;
            w_prox_estado = ST_ANG;
            w_prox_k      = 2'd1;
          end else begin
            w_prox_estado = ST_IDLE;
          end
        end
        ST_ANG: begin
          if (!w_bad && w_digit) begin
            w_st_ang = 1'b1;
            if (r_k == 2'd2) begin
              w_prox_estado = ST_VIRG;
              w_prox_k      = 2'd0;
            end else begin
              w_prox_k = r_k + 2'd1;
            end
          end else begin
            w_abort       = 1'b1;
            w_prox_estado = ST_IDLE;
            w_prox_k      = 2'd0;
          end
        end
        ST_VIRG: begin
          if (!w_bad && (w_dado == ASCII_VIRGULA)) begin
            w_prox_estado = ST_DIST;
            w_prox_k      = 2'd0;
          end else begin
            w_abort       = 1'b1;
            w_prox_estado = ST_IDLE;
            w_prox_k      = 2'd0;
          end
        end
        ST_DIST: begin
          if (!w_bad && w_digit) begin
            w_st_dist = 1'b1;
            if (r_k == 2'd2) begin
              w_prox_estado = ST_FIM;
              w_prox_k      = 2'd0;
            end else begin
              w_prox_k = r_k + 2'd1;
            end
          end else begin
            w_abort       = 1'b1;
            w_prox_estado = ST_IDLE;
            w_prox_k      = 2'd0;
          end
        end
        ST_FIM: begin
          if (!w_bad && (w_dado == ASCII_CERQUILHA)) begin
            w_commit = 1'b1;
          end else begin
            w_abort = 1'b1;
          end
          w_prox_estado = ST_IDLE;
          w_prox_k      = 2'd0;
        end
        default: begin
          w_abort       = 1'b1;
          w_prox_estado = ST_IDLE;
          w_prox_k      = 2'd0;
        end
      endcase
    end else if (w_timeout) begin
      w_abort       = 1'b1;
      w_prox_estado = ST_IDLE;
      w_prox_k      = 2'd0;
    end else begin
      w_prox_estado = r_estado;
    end
  end

  // Parser state, scratch digits (k=0 is the hundreds digit) and idle timer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= ST_IDLE;
      r_k      <= 2'd0;
      r_ang    <= 12'd0;
      r_dist   <= 12'd0;
      r_tmo    <= '0;
    end else begin
      r_estado <= w_prox_estado;
      r_k      <= w_prox_k;
      if (w_st_ang) begin
        case (r_k)
          2'd0:    r_ang[11:8] <= w_dado[3:0];
          2'd1:    r_ang[7:4]  <= w_dado[3:0];
          2'd2:    r_ang[3:0]  <= w_dado[3:0];
          default: r_ang       <= r_ang;
        endcase
      end
      if (w_st_dist) begin
        case (r_k)
          2'd0:    r_dist[11:8] <= w_dado[3:0];
          2'd1:    r_dist[7:4]  <= w_dado[3:0];
          2'd2:    r_dist[3:0]  <= w_dado[3:0];
          default: r_dist       <= r_dist;
        endcase
      end
      if (w_pronto || w_timeout || (r_estado == ST_IDLE)) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  // Published outputs change only on commit so angle and distance never tear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      angulo             <= 12'd0;
      distancia          <= 12'd0;
      frame_valido       <= 1'b0;
      erro_frame         <= 1'b0;
      alerta_proximidade <= 1'b0;
      num_quadros        <= 8'd0;
    end else begin
      frame_valido <= w_commit;
      erro_frame   <= w_abort;
      if (w_commit) begin
        angulo             <= r_ang;
        distancia          <= r_dist;
        num_quadros        <= num_quadros + 8'd1;
        alerta_proximidade <= bcd3_to_bin(r_dist) < 10'(LIMIAR_CM);
      end
    end
  end

  assign db_estado = r_estado;

endmodule

// File: tb/tb_sonar_rx_decoder.sv
// Directed bench for sonar_rx_decoder using a short bit period and timeout.
module tb_sonar_rx_decoder;

  localparam int CPB = 2;
  localparam int TMO = 100;

  logic        clock;
  logic        reset;
  logic        entrada_serial;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        frame_valido;
  logic        erro_frame;
  logic        alerta_proximidade;
  logic [7:0]  num_quadros;
  logic [3:0]  db_estado;

  int n_total = 0;
  int n_pass  = 0;
  int n_fv    = 0;
  int n_er    = 0;
  int fv0;
  int er0;
  int waited;

  sonar_rx_decoder #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TMO),
    .LIMIAR_CM    (20)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .entrada_serial     (entrada_serial),
    .angulo             (angulo),
    .distancia          (distancia),
    .frame_valido       (frame_valido),
    .erro_frame         (erro_frame),
    .alerta_proximidade (alerta_proximidade),
    .num_quadros        (num_quadros),
    .db_estado          (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters for frame_valido and erro_frame.
  always @(posedge clock) begin
    if (frame_valido) n_fv <= n_fv + 1;
    if (erro_frame)   n_er <= n_er + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_char(input logic [7:0] c, input logic flip);
    logic [9:0] f;
    logic       p;
    p = (~(^c[6:0])) ^ flip;
    f = {1'b1, p, c[6:0], 1'b0};
    for (int b = 0; b < 10; b++) begin
      entrada_serial = f[b];
      repeat (CPB) @(posedge clock);
      #1;
    end
    entrada_serial = 1'b1;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    entrada_serial = 1'b1;
    wait_cyc(3);
    chk("rst_ang",   32'(angulo), 32'h0);
    chk("rst_dist",  32'(distancia), 32'h0);
    chk("rst_fv",    32'(frame_valido), 32'h0);
    chk("rst_err",   32'(erro_frame), 32'h0);
    chk("rst_alert", 32'(alerta_proximidade), 32'h0);
    chk("rst_num",   32'(num_quadros), 32'h0);
    chk("rst_est",   32'(db_estado), 32'h0);
    reset = 1'b1;
    wait_cyc(3);

    // First frame, with exact commit latency.
    send_str("045,123#");
    chk("lat_early", 32'(frame_valido), 32'h0);
    wait_cyc(1);
    chk("lat_fv",    32'(frame_valido), 32'h1);
    chk("f1_ang",    32'(angulo), 32'h045);
    chk("f1_dist",   32'(distancia), 32'h123);
    chk("f1_alert",  32'(alerta_proximidade), 32'h0);
    chk("f1_num",    32'(num_quadros), 32'h1);
    wait_cyc(1);
    chk("fv_width",  32'(frame_valido), 32'h0);
    chk("f1_noerr",  32'(n_er), 32'h0);

    send_str("090,015#");
    wait_cyc(2);
    chk("f2_ang",    32'(angulo), 32'h090);
    chk("f2_dist",   32'(distancia), 32'h015);
    chk("f2_alert",  32'(alerta_proximidade), 32'h1);
    chk("f2_num",    32'(num_quadros), 32'h2);

    send_str("090,020#");
    wait_cyc(2);
    chk("f3_alert",  32'(alerta_proximidade), 32'h0);
    chk("f3_num",    32'(num_quadros), 32'h3);

    // Semicolon instead of comma aborts; the trailing "123#" aborts again at '#'.
    er0 = n_er; fv0 = n_fv;
    send_str("045;");
    wait_cyc(2);
    chk("semi_err",  32'(n_er - er0), 32'h1);
    send_str("123#");
    wait_cyc(2);
    chk("semi_err2", 32'(n_er - er0), 32'h2);
    chk("semi_nofv", 32'(n_fv - fv0), 32'h0);
    chk("semi_ang",  32'(angulo), 32'h090);
    chk("semi_dist", 32'(distancia), 32'h020);
    chk("semi_est",  32'(db_estado), 32'h0);

    send_str("180,002#");
    wait_cyc(2);
    chk("f4_ang",    32'(angulo), 32'h180);
    chk("f4_dist",   32'(distancia), 32'h002);
    chk("f4_alert",  32'(alerta_proximidade), 32'h1);
    chk("f4_num",    32'(num_quadros), 32'h4);

    // Bad parity on '4': aborts at '4', then at ',' and '#' of the remainder.
    er0 = n_er; fv0 = n_fv;
    send_char(8'h30, 1'b0);
    send_char(8'h34, 1'b1);
    send_str("5,123#");
    wait_cyc(2);
    chk("par_err",   32'(n_er - er0), 32'h3);
    chk("par_nofv",  32'(n_fv - fv0), 32'h0);
    chk("par_ang",   32'(angulo), 32'h180);

    er0 = n_er;
    send_char(8'h78, 1'b0);
    send_char(8'h2C, 1'b1);
    wait_cyc(2);
    chk("idle_noerr", 32'(n_er - er0), 32'h0);
    chk("idle_est",   32'(db_estado), 32'h0);

    // Inter-character timeout.
    er0 = n_er;
    send_str("04");
    wait_cyc(2);
    chk("tmo_ang_st", 32'(db_estado), 32'h1);
    wait_cyc(50);
    chk("tmo_early",  32'(n_er - er0), 32'h0);
    waited = 0;
    while ((n_er == er0) && (waited < 300)) begin
      wait_cyc(1);
      waited++;
    end
    wait_cyc(5);
    chk("tmo_err",    32'(n_er - er0), 32'h1);
    chk("tmo_est",    32'(db_estado), 32'h0);

    // Asynchronous reset in the middle of a character.
    send_str("045,1");
    entrada_serial = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    #1;
    chk("mid_ang",   32'(angulo), 32'h0);
    chk("mid_dist",  32'(distancia), 32'h0);
    chk("mid_alert", 32'(alerta_proximidade), 32'h0);
    chk("mid_num",   32'(num_quadros), 32'h0);
    chk("mid_est",   32'(db_estado), 32'h0);
    entrada_serial = 1'b1;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(3);
    fv0 = n_fv;
    send_str("123,456#");
    wait_cyc(2);
    chk("post_ang",   32'(angulo), 32'h123);
    chk("post_dist",  32'(distancia), 32'h456);
    chk("post_alert", 32'(alerta_proximidade), 32'h0);
    chk("post_num",   32'(num_quadros), 32'h1);

    // 256 valid frames since reset: counter wraps to 0.
    for (int i = 0; i < 254; i++) send_str($sformatf("%03d,%03d#", i, 255 - i));
    wait_cyc(2);
    chk("num_255",   32'(num_quadros), 32'hFF);
    send_str("254,001#");
    wait_cyc(2);
    chk("num_wrap",  32'(num_quadros), 32'h0);
    chk("wrap_ang",  32'(angulo), 32'h254);
    chk("wrap_dist", 32'(distancia), 32'h001);
    chk("wrap_alert", 32'(alerta_proximidade), 32'h1);
    chk("wrap_fvcnt", 32'(n_fv - fv0), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sonar_rx_decoder.md
Name: sonar_rx_decoder

Overview:
Downstream consumer of the sonar's serial output line (saida_serial). Receives 7O1 UART characters and parses the ASCII frame "AAA,DDD#", where AAA is the angle and DDD is the distance, both in decimal. Publishes the last valid angle and distance as BCD, plus a proximity alert and error/debug flags. Used on a second board, or in loopback, to drive 7-segment displays and the host-side monitor.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud)
TIMEOUT_CLKS, 50000, maximum idle cycles between characters inside a frame (1 ms)
LIMIAR_CM, 20, proximity threshold in cm; alert when distance < LIMIAR_CM

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset (0 = reset)
entrada_serial  in  1  UART line, idle high
angulo  out  12  BCD angle {centena,dezena,unidade} of the last valid frame
distancia  out  12  BCD distance {centena,dezena,unidade} of the last valid frame
frame_valido  out  1  1-cycle pulse when a complete valid frame is latched
erro_frame  out  1  1-cycle pulse when a frame is aborted
alerta_proximidade  out  1  level; distance of the last valid frame < LIMIAR_CM
num_quadros  out  8  count of valid frames, wraps 255->0
db_estado  out  4  parser state encoding

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0; db_estado = IDLE (0).
  - RX and parser return to idle; any partial frame is discarded.
  - After release, the first falling edge on the line starts a new character.
- RX sub-block:
  - Input passes through a 2-flop synchronizer.
  - Start is detected on a synchronized 1->0 transition while idle, then the line is sampled at CLKS_PER_BIT/2 into the bit.
  - If the start bit reads 1 at mid-bit, the event is a glitch: return to idle with no output.
  - Samples 7 data bits LSB first, then parity, then stop, each CLKS_PER_BIT apart.
  - After the stop sample, rx_pronto pulses for 1 cycle with dado[6:0], err_par (odd parity violated) and err_stop (stop bit = 0).
  - RX is re-armed in the cycle after the stop sample.
- Parser FSM, advanced only on rx_pronto. Encodings: IDLE=0, ANG=1, VIRG=2, DIST=3, FIM=4. Digit index k ranges 0..2.
  - IDLE: a digit ('0'..'9', 0x30-0x39) stores ang[0] and goes to ANG with k=1. Any other character is ignored silently.
  - ANG: a digit stores ang[k]; when k=2 go to VIRG, else k++.
  - VIRG: ',' (0x2C) goes to DIST with k=0.
  - DIST: a digit stores dist[k]; when k=2 go to FIM, else k++.
  - FIM: '#' (0x23) commits the frame and returns to IDLE.
- Abort:
  - Triggered in any non-IDLE state by an unexpected character, err_par=1, err_stop=1, or an inter-character timeout.
  - Effect: erro_frame pulses, state goes to IDLE, the offending character is discarded, and outputs keep their old values.
- Timeout counter:
  - Cleared on every rx_pronto and while in IDLE.
  - In a non-IDLE state, reaching TIMEOUT_CLKS triggers an abort.
- Commit, in the cycle after the '#' rx_pronto, all in the same cycle:
  - angulo and distancia update together (no tearing).
  - frame_valido pulses.
  - num_quadros increments.
  - alerta_proximidade <= (100*c + 10*d + u) < LIMIAR_CM, computed on a 10-bit binary value.
- Timing: latency from the stop-bit sample of '#' to frame_valido is 2 cycles (rx_pronto, then commit).
- Hold: alerta_proximidade and all data outputs hold between commits.
- Error priority: if the timeout and rx_pronto occur in the same cycle, rx_pronto wins and the timeout is cleared.

Decomposition:
- Shared package sonar_pkg holds:
  - ASCII constants: ASCII_ZERO=7'h30, ASCII_NOVE=7'h39, ASCII_VIRGULA=7'h2C, ASCII_CERQUILHA=7'h23.
  - Parser state encodings.
  - Default CLKS_PER_BIT.
- One sub-module, rx_serial_7O1: synchronizer, bit-timing counter and shift register, producing dado/rx_pronto/err_par/err_stop.
- The parser, timeout counter, BCD-to-binary compare and frame counter live in sonar_rx_decoder.

Test Plan:
- Send "045,123#" at 115200 baud -> frame_valido pulses once; angulo=12'h045, distancia=12'h123, alerta_proximidade=0, num_quadros=1.
- Send "090,015#" -> distancia=12'h015, alerta_proximidade=1; then "090,020#" -> alerta_proximidade=0 (20 is not < 20).
- Send "045;123#" -> erro_frame pulses at ';'; angulo and distancia keep their previous values; then "180,002#" is accepted normally.
- Send '4' with a wrong parity bit inside "045,123#" -> erro_frame pulses and there is no frame_valido; a garbage character while in IDLE gives no erro_frame.
- Send "04", then idle for more than 50000 cycles -> erro_frame pulses once at timeout; db_estado returns to 0.
- Drive reset=0 mid-character during "045,1" -> all outputs 0 immediately; a following full frame decodes correctly. Also send 256 valid frames -> num_quadros wraps to 0.
